// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Register file geometry and loader FSM state encoding.
// Revision : 1.0
// ============================================================================
package cpu_pkg;

    localparam int REG_AW = 3;
    localparam int REG_DW = 8;
    localparam int REG_N  = 8;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        LOAD        = 3'd1,
        VERIFY_ADDR = 3'd2,
        VERIFY_CMP  = 3'd3,
        DONE        = 3'd4
    } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/reg_loader_buf.sv
`default_nettype none
// ============================================================================
// Module   : reg_loader_buf
// Purpose  : Byte buffer holding the streamed bytes for readback compare.
//            Only built when REG_LOADER_VERIFY_EN is defined.
// Revision : 1.0
// ============================================================================
`ifdef REG_LOADER_VERIFY_EN
module reg_loader_buf
    import cpu_pkg::*;
#(
    parameter int NREGS = REG_N,
    parameter int AW    = REG_AW,
    parameter int DW    = REG_DW
) (
    input  logic          CLK,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_idx,
    input  logic [DW-1:0] i_wr_data,
    input  logic [AW-1:0] i_rd_idx,
    output logic [DW-1:0] o_rd_data
);

    logic [DW-1:0] r_mem [NREGS];

    always_ff @(posedge CLK) begin
        if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_idx];

endmodule
`endif
`default_nettype wire

// File: rtl/reg_loader.sv
`default_nettype none
// ============================================================================
// Module   : reg_loader
// Purpose  : Fills a wrapping run of register-file entries from a byte stream.
//            Optional readback check enabled by REG_LOADER_VERIFY_EN.
// Revision : 1.0
// ============================================================================
module reg_loader
    import cpu_pkg::*;
#(
    parameter int NREGS = REG_N,
    parameter int AW    = REG_AW,
    parameter int DW    = REG_DW
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          START,
    input  logic [AW-1:0] BASE,
    input  logic [AW:0]   COUNT,
    input  logic [DW-1:0] S_DATA,
    input  logic          S_VALID,
    output logic          S_READY,
    output logic [DW-1:0] IN,
    output logic [AW-1:0] INADDRESS,
    output logic          WRITE,
    output logic [AW-1:0] OUT1ADDRESS,
    input  logic [DW-1:0] OUT1,
    output logic          BUSY,
    output logic          DONE,
    output logic          ERR
);

    localparam logic [AW:0] c_nregs = (AW+1)'(NREGS);

    loader_state_t r_state;
    loader_state_t w_next;

    logic [AW-1:0] r_base;
    logic [AW:0]   r_count;
    logic [AW:0]   r_idx;
    logic          r_write;
    logic [DW-1:0] r_in;
    logic [AW-1:0] r_inaddr;

    logic [AW:0]   w_count_clamped;
    logic          w_xfer;
    logic          w_last_xfer;
    logic          w_start_acc;
    logic          w_verify_last;

    assign w_count_clamped = (COUNT > c_nregs) ? c_nregs : COUNT;
    assign w_start_acc     = (r_state == IDLE) && START;
    assign w_xfer          = S_VALID && (r_state == LOAD);
    assign w_last_xfer     = w_xfer && (r_idx == r_count - 1'b1);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (START) begin
                    w_next = (w_count_clamped == '0) ? cpu_pkg::DONE : LOAD;
                end
            end
            LOAD: begin
                if (w_last_xfer) begin
`ifdef REG_LOADER_VERIFY_EN
                    w_next = VERIFY_ADDR;
`else
                    w_next = cpu_pkg::DONE;
`endif
                end
            end
`ifdef REG_LOADER_VERIFY_EN
            VERIFY_ADDR: w_next = VERIFY_CMP;
            VERIFY_CMP:  w_next = w_verify_last ? cpu_pkg::DONE : VERIFY_ADDR;
`endif
            cpu_pkg::DONE: w_next = IDLE;
            default:       w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state  <= IDLE;
            r_base   <= '0;
            r_count  <= '0;
            r_idx    <= '0;
            r_write  <= 1'b0;
            r_in     <= '0;
            r_inaddr <= '0;
        end else begin
            r_state <= w_next;
            r_write <= w_xfer;
            if (w_start_acc) begin
                r_base  <= BASE;
                r_count <= w_count_clamped;
                r_idx   <= '0;
            end
            // Write port is registered: the register file commits one edge later.
            if (w_xfer) begin
                r_in     <= S_DATA;
                r_inaddr <= r_base + r_idx[AW-1:0];
                r_idx    <= r_idx + 1'b1;
            end
        end
    end

    assign S_READY   = (r_state == LOAD);
    assign BUSY      = (r_state != IDLE);
    assign DONE      = (r_state == cpu_pkg::DONE);
    assign WRITE     = r_write;
    assign IN        = r_in;
    assign INADDRESS = r_inaddr;

`ifdef REG_LOADER_VERIFY_EN
    logic [AW:0]   r_vidx;
    logic          r_err;
    logic [DW-1:0] w_buf_rd;

    reg_loader_buf #(
        .NREGS (NREGS),
        .AW    (AW),
        .DW    (DW)
    ) u_buf (
        .CLK       (CLK),
        .i_wr_en   (w_xfer),
        .i_wr_idx  (r_idx[AW-1:0]),
        .i_wr_data (S_DATA),
        .i_rd_idx  (r_vidx[AW-1:0]),
        .o_rd_data (w_buf_rd)
    );

    assign w_verify_last = (r_vidx == r_count - 1'b1);

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_vidx <= '0;
            r_err  <= 1'b0;
        end else if (w_start_acc) begin
            r_vidx <= '0;
            r_err  <= 1'b0;
        end else if (r_state == VERIFY_CMP) begin
            if (OUT1 != w_buf_rd) begin
                r_err <= 1'b1;
            end
            r_vidx <= r_vidx + 1'b1;
        end
    end

    assign OUT1ADDRESS = ((r_state == VERIFY_ADDR) || (r_state == VERIFY_CMP))
                         ? r_base + r_vidx[AW-1:0] : '0;
    assign ERR         = r_err;
`else
    logic w_unused_out1;

    assign w_verify_last = 1'b0;
    assign w_unused_out1 = ^{OUT1, w_verify_last};
    assign OUT1ADDRESS   = '0;
    assign ERR           = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_loader.sv
`default_nettype none
// Directed self-checking bench for reg_loader with a behavioural register file.
module tb_reg_loader;

`ifdef REG_LOADER_VERIFY_EN
    localparam int V = 1;
`else
    localparam int V = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [2:0] base;
    logic [3:0] count;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] in_d;
    logic [2:0] inaddr;
    logic       write;
    logic [2:0] out1addr;
    logic [7:0] out1;
    logic       busy;
    logic       done;
    logic       err;

    logic [7:0] rf [8] = '{default: 8'h00};
    logic       corrupt = 1'b0;
    logic [2:0] corrupt_addr = 3'd0;
    int         wr_cnt = 0;
    int         checks = 0;
    int         errors = 0;

    reg_loader dut (
        .CLK         (clk),
        .RESET       (rst_n),
        .START       (start),
        .BASE        (base),
        .COUNT       (count),
        .S_DATA      (s_data),
        .S_VALID     (s_valid),
        .S_READY     (s_ready),
        .IN          (in_d),
        .INADDRESS   (inaddr),
        .WRITE       (write),
        .OUT1ADDRESS (out1addr),
        .OUT1        (out1),
        .BUSY        (busy),
        .DONE        (done),
        .ERR         (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (write) rf[inaddr] <= in_d;
        if (corrupt) rf[corrupt_addr] <= 8'hFF;
    end

    always @(posedge clk) begin
        if (write) wr_cnt <= wr_cnt + 1;
    end

    assign out1 = rf[out1addr];

    // Drives one START and streams bytes d0, d0+1, ... with 'stall' idle cycles after each accept.
    task automatic run_seq(input logic [2:0] b, input logic [3:0] c, input logic [7:0] d0,
                           input int stall, input bit hold, input int corrupt_at,
                           output int lat, output int nwr, output int rdy_hi,
                           output logic err0, output logic err_end,
                           output logic done_next, output logic busy_next);
        int k;
        int st;
        int w0;
        bit xfer;
        w0 = wr_cnt;
        k = 0;
        st = 0;
        rdy_hi = 0;
        base = b;
        count = c;
        start = 1'b1;
        s_valid = 1'b0;
        @(posedge clk); #1;
        if (!hold) begin
            start = 1'b0;
        end else begin
            base = 3'd7;
            count = 4'd8;
        end
        err0 = err;
        lat = 1;
        while (!done && lat < 200) begin
            if (s_ready) rdy_hi++;
            if (st > 0) begin
                s_valid = 1'b0;
                st--;
            end else begin
                s_valid = 1'b1;
                s_data = d0 + 8'(k);
            end
            corrupt = (corrupt_at != 0) && (lat == corrupt_at);
            xfer = s_valid && s_ready;
            @(posedge clk); #1;
            lat++;
            if (xfer) begin
                k++;
                st = stall;
            end
        end
        corrupt = 1'b0;
        err_end = err;
        start = 1'b0;
        s_valid = 1'b0;
        @(posedge clk); #1;
        done_next = done;
        busy_next = busy;
        nwr = wr_cnt - w0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        base = '0;
        count = '0;
        s_data = '0;
        s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready: got %b expected 0", s_ready); end
        checks++; if (write !== 1'b0) begin errors++; $display("FAIL rst_write: got %b expected 0", write); end
        checks++; if (in_d !== 8'h00) begin errors++; $display("FAIL rst_in: got %h expected 00", in_d); end
        checks++; if (inaddr !== 3'd0) begin errors++; $display("FAIL rst_inaddr: got %0d expected 0", inaddr); end
        checks++; if (out1addr !== 3'd0) begin errors++; $display("FAIL rst_out1addr: got %0d expected 0", out1addr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", err); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_load();
        int lat, nwr, rdy;
        logic e0, ee, dn, bn;
        run_seq(3'd0, 4'd8, 8'h10, 0, 1'b0, 0, lat, nwr, rdy, e0, ee, dn, bn);
        checks++; if (lat != 9 + 16 * V) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", lat, 9 + 16 * V); end
        checks++; if (nwr != 8) begin errors++; $display("FAIL basic_writes: got %0d expected 8", nwr); end
        for (int r = 0; r < 8; r++) begin
            checks++;
            if (rf[r] !== 8'h10 + 8'(r)) begin errors++; $display("FAIL basic_R%0d: got %h expected %h", r, rf[r], 8'h10 + 8'(r)); end
        end
        checks++; if (dn !== 1'b0) begin errors++; $display("FAIL basic_done_one_cycle: got %b expected 0", dn); end
        checks++; if (bn !== 1'b0) begin errors++; $display("FAIL basic_idle_after: got busy %b expected 0", bn); end
        checks++; if (ee !== 1'b0) begin errors++; $display("FAIL basic_err: got %b expected 0", ee); end
    endtask

    task automatic test_wrap_stall();
        int lat, nwr, rdy;
        logic e0, ee, dn, bn;
        run_seq(3'd6, 4'd3, 8'hA1, 2, 1'b0, 0, lat, nwr, rdy, e0, ee, dn, bn);
        checks++; if (rf[6] !== 8'hA1) begin errors++; $display("FAIL wrap_R6: got %h expected a1", rf[6]); end
        checks++; if (rf[7] !== 8'hA2) begin errors++; $display("FAIL wrap_R7: got %h expected a2", rf[7]); end
        checks++; if (rf[0] !== 8'hA3) begin errors++; $display("FAIL wrap_R0: got %h expected a3", rf[0]); end
        checks++; if (rf[1] !== 8'h11) begin errors++; $display("FAIL wrap_R1_untouched: got %h expected 11", rf[1]); end
        checks++; if (nwr != 3) begin errors++; $display("FAIL wrap_writes: got %0d expected 3", nwr); end
        checks++; if (lat != 8 + 6 * V) begin errors++; $display("FAIL wrap_latency: got %0d expected %0d", lat, 8 + 6 * V); end
    endtask

    task automatic test_edge_counts();
        int lat, nwr, rdy;
        logic e0, ee, dn, bn;
        run_seq(3'd3, 4'd0, 8'h20, 0, 1'b0, 0, lat, nwr, rdy, e0, ee, dn, bn);
        checks++; if (lat != 1) begin errors++; $display("FAIL cnt0_latency: got %0d expected 1", lat); end
        checks++; if (nwr != 0) begin errors++; $display("FAIL cnt0_writes: got %0d expected 0", nwr); end
        checks++; if (rdy != 0) begin errors++; $display("FAIL cnt0_ready_cycles: got %0d expected 0", rdy); end
        checks++; if (bn !== 1'b0) begin errors++; $display("FAIL cnt0_idle_after: got busy %b expected 0", bn); end
        run_seq(3'd5, 4'd12, 8'h30, 0, 1'b0, 0, lat, nwr, rdy, e0, ee, dn, bn);
        checks++; if (nwr != 8) begin errors++; $display("FAIL cnt12_writes: got %0d expected 8", nwr); end
        checks++; if (lat != 9 + 16 * V) begin errors++; $display("FAIL cnt12_latency: got %0d expected %0d", lat, 9 + 16 * V); end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (rf[(5 + k) % 8] !== 8'h30 + 8'(k)) begin
                errors++;
                $display("FAIL cnt12_R%0d: got %h expected %h", (5 + k) % 8, rf[(5 + k) % 8], 8'h30 + 8'(k));
            end
        end
    endtask

    task automatic test_busy_ignored();
        int lat, nwr, rdy, w0;
        logic e0, ee, dn, bn;
        w0 = wr_cnt;
        s_valid = 1'b1;
        s_data = 8'h55;
        repeat (3) begin
            @(posedge clk); #1;
            checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL idle_s_ready: got %b expected 0", s_ready); end
        end
        s_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (wr_cnt - w0 != 0) begin errors++; $display("FAIL idle_valid_writes: got %0d expected 0", wr_cnt - w0); end
        run_seq(3'd1, 4'd2, 8'h60, 0, 1'b1, 0, lat, nwr, rdy, e0, ee, dn, bn);
        checks++; if (nwr != 2) begin errors++; $display("FAIL busy_start_writes: got %0d expected 2", nwr); end
        checks++; if (lat != 3 + 4 * V) begin errors++; $display("FAIL busy_start_latency: got %0d expected %0d", lat, 3 + 4 * V); end
        checks++; if (rf[1] !== 8'h60) begin errors++; $display("FAIL busy_start_R1: got %h expected 60", rf[1]); end
        checks++; if (rf[2] !== 8'h61) begin errors++; $display("FAIL busy_start_R2: got %h expected 61", rf[2]); end
        checks++; if (rf[7] !== 8'h32) begin errors++; $display("FAIL busy_start_R7: got %h expected 32", rf[7]); end
        checks++; if (bn !== 1'b0) begin errors++; $display("FAIL busy_start_idle_after: got busy %b expected 0", bn); end
    endtask

    task automatic test_reset_mid_load();
        int w0;
        w0 = wr_cnt;
        base = 3'd0;
        count = 4'd8;
        start = 1'b1;
        s_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            s_valid = 1'b1;
            s_data = 8'hC0 + 8'(k);
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++; if (write !== 1'b0) begin errors++; $display("FAIL midrst_write: got %b expected 0", write); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL midrst_s_ready: got %b expected 0", s_ready); end
        checks++; if (in_d !== 8'h00) begin errors++; $display("FAIL midrst_in: got %h expected 00", in_d); end
        checks++; if (inaddr !== 3'd0) begin errors++; $display("FAIL midrst_inaddr: got %0d expected 0", inaddr); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b expected 0", done); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        s_valid = 1'b0;
        checks++; if (wr_cnt - w0 != 3) begin errors++; $display("FAIL midrst_writes: got %0d expected 3", wr_cnt - w0); end
        checks++; if (rf[2] !== 8'hC2) begin errors++; $display("FAIL midrst_R2: got %h expected c2", rf[2]); end
        checks++; if (rf[3] !== 8'h36) begin errors++; $display("FAIL midrst_R3: got %h expected 36", rf[3]); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_idle: got busy %b expected 0", busy); end
    endtask

    task automatic test_verify();
        int lat, nwr, rdy;
        logic e0, ee, dn, bn;
        corrupt_addr = 3'd3;
        run_seq(3'd2, 4'd2, 8'h80, 0, 1'b0, 4, lat, nwr, rdy, e0, ee, dn, bn);
        checks++; if (ee !== 1'b1) begin errors++; $display("FAIL verify_err_set: got %b expected 1", ee); end
        checks++; if (lat != 7) begin errors++; $display("FAIL verify_latency: got %0d expected 7", lat); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL verify_err_sticky: got %b expected 1", err); end
        run_seq(3'd2, 4'd2, 8'h90, 0, 1'b0, 0, lat, nwr, rdy, e0, ee, dn, bn);
        checks++; if (e0 !== 1'b0) begin errors++; $display("FAIL verify_err_cleared: got %b expected 0", e0); end
        checks++; if (ee !== 1'b0) begin errors++; $display("FAIL verify_clean_err: got %b expected 0", ee); end
        checks++; if (rf[3] !== 8'h91) begin errors++; $display("FAIL verify_clean_R3: got %h expected 91", rf[3]); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_load();
        test_wrap_stall();
        test_edge_counts();
        test_busy_ignored();
        test_reset_mid_load();
`ifdef REG_LOADER_VERIFY_EN
        test_verify();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
